// File: rtl/rv_bus_pkg.sv
// Shared definitions for the picorv32 memory-bus decoder: FSM state
// encoding, error-cause codes and the slave-index width.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ERR    = 2'b10
    } rv_bus_state_t;

    localparam logic [1:0] RV_BUS_ERR_NONE     = 2'b00;
    localparam logic [1:0] RV_BUS_ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] RV_BUS_ERR_TIMEOUT  = 2'b10;

    // Wide enough to index up to 8 slaves.
    localparam int RV_BUS_IDX_W = 3;

endpackage

// File: rtl/rv_bus_addr_match.sv
// Combinational address decoder: compares the upper address bits against
// every slave base and reports a hit plus the lowest matching slave index.
module rv_bus_addr_match
    import rv_bus_pkg::*;
#(
    parameter int                                NUM_SLAVES = 4,
    parameter int                                MATCH_BITS = 16,
    parameter logic [NUM_SLAVES*MATCH_BITS-1:0]  SLAVE_BASE = '0
) (
    input  logic [MATCH_BITS-1:0]   i_addr_hi,
    output logic                    o_hit,
    output logic [RV_BUS_IDX_W-1:0] o_idx
);

    // Scan from the highest slot down so the lowest matching slot wins.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (i_addr_hi == SLAVE_BASE[k*MATCH_BITS +: MATCH_BITS]) begin
                o_hit = 1'b1;
                o_idx = RV_BUS_IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rv_bus_decoder.sv
// Single-master, N-slave decoder for the picorv32 native memory bus.
// The target slave is decoded once per transaction and held in r_sel;
// unmapped accesses (and, when RV_BUS_TIMEOUT_EN is defined, slaves that
// never answer) get a one-cycle error response and are recorded in sticky
// status registers.
// Optional feature macro: RV_BUS_TIMEOUT_EN (timeout counter + ERR on timeout).
module rv_bus_decoder
    import rv_bus_pkg::*;
#(
    parameter int                                NUM_SLAVES     = 4,
    parameter int                                MATCH_BITS     = 16,
    parameter logic [NUM_SLAVES*MATCH_BITS-1:0]  SLAVE_BASE     = {16'h4000, 16'h3000, 16'h2000, 16'h1000},
    parameter int                                TIMEOUT_CYCLES = 64,
    parameter logic [31:0]                       ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic                     err_clr,
    output logic                     bus_err,
    output logic [1:0]               err_cause,
    output logic [31:0]              err_addr
);

    rv_bus_state_t           r_state;
    logic [RV_BUS_IDX_W-1:0] r_sel;
    logic                    r_bus_err;
    logic [1:0]              r_err_cause;
    logic [31:0]             r_err_addr;

    logic                    w_hit;
    logic [RV_BUS_IDX_W-1:0] w_idx;
    logic                    w_sel_ready;
    logic [31:0]             w_sel_rdata;
    logic                    w_err_enter;
    logic [1:0]              w_err_code;

`ifdef RV_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]            r_tcnt;
    logic                   w_timeout;
`endif

    rv_bus_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .MATCH_BITS (MATCH_BITS),
        .SLAVE_BASE (SLAVE_BASE)
    ) u_match (
        .i_addr_hi (m_addr[31 -: MATCH_BITS]),
        .o_hit     (w_hit),
        .o_idx     (w_idx)
    );

    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign bus_err   = r_bus_err;
    assign err_cause = r_err_cause;
    assign err_addr  = r_err_addr;

    // Pick the ready/rdata of the slave latched for this transaction.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (int'(r_sel) == k) begin
                w_sel_ready = s_ready[k];
                w_sel_rdata = s_rdata[k*32 +: 32];
            end
        end
    end

`ifdef RV_BUS_TIMEOUT_EN
    assign w_timeout = (r_state == ST_ACTIVE) && m_valid && !w_sel_ready &&
                       (r_tcnt == TO_LAST);
`endif

    // Detect the cycle in which the FSM moves into ERR and why.
    always_comb begin
        w_err_enter = 1'b0;
        w_err_code  = RV_BUS_ERR_NONE;
        if ((r_state == ST_IDLE) && m_valid && !w_hit) begin
            w_err_enter = 1'b1;
            w_err_code  = RV_BUS_ERR_UNMAPPED;
        end
`ifdef RV_BUS_TIMEOUT_EN
        if (w_timeout) begin
            w_err_enter = 1'b1;
            w_err_code  = RV_BUS_ERR_TIMEOUT;
        end
`endif
    end

    // Drive the master response and the one-hot slave request from the state.
    always_comb begin
        m_ready = 1'b0;
        m_rdata = '0;
        s_valid = '0;
        case (r_state)
            ST_ACTIVE: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (int'(r_sel) == k) begin
                        s_valid[k] = m_valid;
                    end
                end
                m_ready = w_sel_ready;
                m_rdata = w_sel_rdata;
            end
            ST_ERR: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

    // Transaction FSM: decode in IDLE, wait for the slave in ACTIVE, one-cycle ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
`ifdef RV_BUS_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (w_hit) begin
                            r_sel   <= w_idx;
                            r_state <= ST_ACTIVE;
`ifdef RV_BUS_TIMEOUT_EN
                            r_tcnt  <= '0;
`endif
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
`ifdef RV_BUS_TIMEOUT_EN
                    if (!w_sel_ready) begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
`endif
                    if (!m_valid || w_sel_ready) begin
                        r_state <= ST_IDLE;
                    end
`ifdef RV_BUS_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end
`endif
                end
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error status: first error since clear is kept; a capture beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_err   <= 1'b0;
            r_err_cause <= RV_BUS_ERR_NONE;
            r_err_addr  <= '0;
        end else if (w_err_enter && !r_bus_err) begin
            r_bus_err   <= 1'b1;
            r_err_cause <= w_err_code;
            r_err_addr  <= m_addr;
        end else if (err_clr) begin
            r_bus_err   <= 1'b0;
            r_err_cause <= RV_BUS_ERR_NONE;
            r_err_addr  <= '0;
        end
    end

endmodule
